// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: per-cache miss handler feeding the replacement policy (victim pick, write-back, burst refill, commit).
// Optional dirty-victim write-back is built in when `REFILL_WRITEBACK_EN is defined; otherwise the cache is write-through.
module cache_refill_ctrl #(
  parameter int unsigned SET_ASSOC  = 4,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned BUS_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lookup_valid,
  input  logic [SET_ASSOC-1:0]         hit_way,
  input  logic [31:0]                  miss_addr,
  input  logic [SET_ASSOC-1:0]         way_valid,
  input  logic [SET_ASSOC-1:0]         way_dirty,
  input  logic [$clog2(SET_ASSOC)-1:0] repl_index,
  input  logic [31:0]                  victim_addr,
  input  logic [LINE_WIDTH-1:0]        victim_line,
  output logic [SET_ASSOC-1:0]         repl_access,
  output logic                         repl_update,
  output logic                         busy,
  output logic [$clog2(SET_ASSOC)-1:0] victim_way,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [31:0]                  wb_addr,
  output logic [BUS_WIDTH-1:0]         wb_data,
  output logic                         wb_last,
  output logic                         rd_req,
  input  logic                         rd_gnt,
  output logic [31:0]                  rd_addr,
  input  logic                         rd_valid,
  input  logic [BUS_WIDTH-1:0]         rd_data,
  input  logic                         rd_last,
  output logic                         line_we,
  output logic [LINE_WIDTH-1:0]        line_data,
  output logic                         refill_done
);

  localparam int unsigned IDX_W = $clog2(SET_ASSOC);
  localparam int unsigned BEATS = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [31:0]      LINE_MASK = ~32'(LINE_WIDTH / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
`ifdef REFILL_WRITEBACK_EN
    WB      = 3'd1,
`endif
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            full_q, full_d;
  logic                            busy_q, busy_d;
  logic [IDX_W-1:0]                victim_way_q, victim_way_d;
  logic [SET_ASSOC-1:0]            repl_access_q, repl_access_d;
  logic                            repl_update_q, repl_update_d;
  logic                            rd_req_q, rd_req_d;
  logic [31:0]                     rd_addr_q, rd_addr_d;
  logic [BEATS-1:0][BUS_WIDTH-1:0] line_q, line_d;
  logic                            line_we_q, line_we_d;
  logic                            refill_done_q, refill_done_d;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_way;
  logic             capture;

`ifdef REFILL_WRITEBACK_EN
  logic                            wb_valid_q, wb_valid_d;
  logic [31:0]                     wb_addr_q, wb_addr_d;
  logic [BUS_WIDTH-1:0]            wb_data_q, wb_data_d;
  logic                            wb_last_q, wb_last_d;
  logic [CNT_W-1:0]                wb_beat;
  logic [BEATS-1:0][BUS_WIDTH-1:0] victim_beats;

  assign victim_beats = victim_line;
`else
  logic unused_wb;

  assign unused_wb = ^{way_dirty, wb_ready, victim_addr, victim_line};
`endif

  // Victim choice: lowest-index invalid way, else the policy's pick.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(SET_ASSOC); i++) begin
      if (!way_valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_way = free_found ? free_idx : repl_index;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    full_d        = full_q;
    busy_d        = busy_q;
    victim_way_d  = victim_way_q;
    repl_access_d = '0;
    repl_update_d = 1'b0;
    rd_req_d      = rd_req_q;
    rd_addr_d     = rd_addr_q;
    line_d        = line_q;
    line_we_d     = 1'b0;
    refill_done_d = 1'b0;
    capture       = 1'b0;
`ifdef REFILL_WRITEBACK_EN
    wb_valid_d    = wb_valid_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    wb_last_d     = wb_last_q;
    wb_beat       = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (lookup_valid) begin
          if (hit_way != '0) begin
            repl_update_d = 1'b1;
            repl_access_d = hit_way;
          end else begin
            busy_d       = 1'b1;
            victim_way_d = sel_way;
            rd_addr_d    = miss_addr & LINE_MASK;
`ifdef REFILL_WRITEBACK_EN
            if (way_valid[sel_way] && way_dirty[sel_way]) begin
              state_d = WB;
            end else begin
              state_d  = RD_REQ;
              rd_req_d = 1'b1;
            end
`else
            state_d  = RD_REQ;
            rd_req_d = 1'b1;
`endif
          end
        end
      end
`ifdef REFILL_WRITEBACK_EN
      // victim_addr/line only become valid after acceptance, so the first beat registers one cycle in.
      WB: begin
        if (wb_valid_q && wb_ready && wb_last_q) begin
          wb_valid_d = 1'b0;
          wb_last_d  = 1'b0;
          cnt_d      = '0;
          state_d    = RD_REQ;
          rd_req_d   = 1'b1;
        end else if (!wb_valid_q || wb_ready) begin
          wb_beat    = wb_valid_q ? cnt_q + CNT_W'(1) : cnt_q;
          cnt_d      = wb_beat;
          wb_valid_d = 1'b1;
          wb_addr_d  = victim_addr + (32'(wb_beat) << 2);
          wb_data_d  = victim_beats[wb_beat];
          wb_last_d  = (wb_beat == LAST_BEAT);
        end
      end
`endif
      RD_REQ: begin
        if (rd_gnt) begin
          rd_req_d = 1'b0;
          state_d  = RD_DATA;
          capture  = 1'b1;
        end
      end
      RD_DATA: capture = 1'b1;
      COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        full_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Beat capture; a beat arriving with the grant counts as beat 0.
    if (capture && rd_valid && !full_q) begin
      line_d[cnt_q] = rd_data;
      cnt_d         = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_BEAT) begin
        if (rd_last) begin
          state_d       = COMMIT;
          line_we_d     = 1'b1;
          refill_done_d = 1'b1;
          repl_update_d = 1'b1;
          repl_access_d = SET_ASSOC'(1) << victim_way_q;
        end else begin
          full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      full_q        <= 1'b0;
      busy_q        <= 1'b0;
      victim_way_q  <= '0;
      repl_access_q <= '0;
      repl_update_q <= 1'b0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      line_q        <= '0;
      line_we_q     <= 1'b0;
      refill_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      full_q        <= full_d;
      busy_q        <= busy_d;
      victim_way_q  <= victim_way_d;
      repl_access_q <= repl_access_d;
      repl_update_q <= repl_update_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      line_q        <= line_d;
      line_we_q     <= line_we_d;
      refill_done_q <= refill_done_d;
    end
  end

`ifdef REFILL_WRITEBACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_last_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      wb_last_q  <= wb_last_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign wb_last  = wb_last_q;
`else
  assign wb_valid = 1'b0;
  assign wb_addr  = '0;
  assign wb_data  = '0;
  assign wb_last  = 1'b0;
`endif

  assign repl_access = repl_access_q;
  assign repl_update = repl_update_q;
  assign busy        = busy_q;
  assign victim_way  = victim_way_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign line_we     = line_we_q;
  assign line_data   = line_q;
  assign refill_done = refill_done_q;

endmodule
